// File: rtl/counter_pkg.sv
// Shared types and constants for the count sequencer and its counter datapath.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int W_DEFAULT = 8;

endpackage

// File: rtl/count_core.sv
// Registered up/down counter with a synchronous load; wraps modulo 2^W.
module count_core
    import counter_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         step,
    input  logic         dir,
    output logic [W-1:0] count
);

    // Load wins over step so a reload on a terminal edge never also steps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (step) begin
            if (dir == DIR_DOWN) begin
                count <= count - W'(1);
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven sequencer for an up/down counter.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for a command; cmd_ready high
//  RUN   | prescaler running, count steps once every div+1 cycles
//  HOLD  | paused; prescaler and count frozen until pause drops
module count_sequencer
    import counter_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W-1:0]      cmd_start,
    input  logic [W-1:0]      cmd_end,
    input  logic              cmd_dir,
    input  logic [7:0]        cmd_div,
    input  logic              cmd_reload,
    input  logic              pause,
    input  logic              abort,
    output logic [W-1:0]      count,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    state_t              state, state_nxt;
    logic [7:0]          prescaler, prescaler_nxt;
    logic [PASS_W-1:0]   pass_nxt;
    logic                done_nxt;
    logic                busy_nxt;
    logic                paused_nxt;
    logic                latch;

    logic [W-1:0]        start_q;
    logic [W-1:0]        end_q;
    logic                dir_q;
    logic [7:0]          div_q;
    logic                reload_q;

    logic                core_load;
    logic [W-1:0]        core_value;
    logic                core_step;

    assign cmd_ready = (state == IDLE);

    count_core #(.W(W)) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (core_load),
        .value (core_value),
        .step  (core_step),
        .dir   (dir_q),
        .count (count)
    );

    // State register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            prescaler <= '0;
            pass_cnt  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            paused    <= 1'b0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            pass_cnt  <= pass_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            paused    <= paused_nxt;
        end
    end

    // Command fields captured on accept; they stay put for the whole run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q  <= '0;
            end_q    <= '0;
            dir_q    <= 1'b0;
            div_q    <= '0;
            reload_q <= 1'b0;
        end else if (latch) begin
            start_q  <= cmd_start;
            end_q    <= cmd_end;
            dir_q    <= cmd_dir;
            div_q    <= cmd_div;
            reload_q <= cmd_reload;
        end
    end

    // Next-state, prescaler, terminal compare and counter control.
    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        pass_nxt      = pass_cnt;
        done_nxt      = 1'b0;
        latch         = 1'b0;
        core_load     = 1'b0;
        core_value    = start_q;
        core_step     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    latch         = 1'b1;
                    core_load     = 1'b1;
                    core_value    = cmd_start;
                    prescaler_nxt = '0;
                    pass_nxt      = '0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else if (prescaler == div_q) begin
                    prescaler_nxt = '0;
                    if (count == end_q) begin
                        done_nxt = 1'b1;
                        if (pass_cnt != '1) begin
                            pass_nxt = pass_cnt + PASS_W'(1);
                        end
                        if (reload_q) begin
                            core_load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        core_step = 1'b1;
                    end
                end else begin
                    prescaler_nxt = prescaler + 8'd1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt   = (state_nxt != IDLE);
        paused_nxt = (state_nxt == HOLD);
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with hand-computed expectations.
module tb_count_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_end;
    logic       cmd_dir;
    logic [7:0] cmd_div;
    logic       cmd_reload;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       paused;
    logic       done;
    logic [7:0] pass_cnt;

    int n_cmp;
    int n_bad;

    count_sequencer #(.W(8), .PASS_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_end    (cmd_end),
        .cmd_dir    (cmd_dir),
        .cmd_div    (cmd_div),
        .cmd_reload (cmd_reload),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .pass_cnt   (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns later, inputs changed there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] s, input logic [7:0] e, input logic d,
                            input logic [7:0] v, input logic r);
        cmd_start  = s;
        cmd_end    = e;
        cmd_dir    = d;
        cmd_div    = v;
        cmd_reload = r;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        int done_hits;
        int exp_pass;
        logic [7:0] down_seq [5];
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_end = '0; cmd_dir = 1'b0;
        cmd_div = '0; cmd_reload = 1'b0; pause = 1'b0; abort = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("init_ready", cmd_ready, 1);
        chk("init_count", count, 0);

        // Reset mid-run at count 5.
        send_cmd(8'd0, 8'd9, 1'b0, 8'd0, 1'b0);
        repeat (5) tick();
        chk("pre_rst_count", count, 5);
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paused", paused, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_ready", cmd_ready, 1);
        tick();
        chk("rst_hold_busy", busy, 0);

        // One-shot up 3..7.
        send_cmd(8'd3, 8'd7, 1'b0, 8'd0, 1'b0);
        chk("up_count0", count, 3);
        chk("up_busy", busy, 1);
        chk("up_ready", cmd_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("up_count", count, 3 + i);
            chk("up_nodone", done, 0);
        end
        tick();
        chk("up_done", done, 1);
        chk("up_idle", busy, 0);
        chk("up_final", count, 7);
        chk("up_pass", pass_cnt, 1);
        chk("up_ready_end", cmd_ready, 1);
        tick();
        chk("up_done_pulse", done, 0);

        // Down with wrap 2 -> 254.
        down_seq[0] = 8'd2; down_seq[1] = 8'd1; down_seq[2] = 8'd0;
        down_seq[3] = 8'd255; down_seq[4] = 8'd254;
        send_cmd(8'd2, 8'd254, 1'b1, 8'd0, 1'b0);
        chk("dn_count", count, down_seq[0]);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("dn_count", count, down_seq[i]);
            chk("dn_nodone", done, 0);
        end
        tick();
        chk("dn_done", done, 1);
        chk("dn_idle", busy, 0);
        chk("dn_final", count, 254);
        tick();
        chk("dn_done_pulse", done, 0);

        // Auto-reload 10..12 with div=1.
        send_cmd(8'd10, 8'd12, 1'b0, 8'd1, 1'b1);
        chk("rl_count0", count, 10);
        for (int c = 1; c <= 18; c++) begin
            tick();
            chk("rl_count", count, 10 + ((c % 6) / 2));
            chk("rl_done", done, (c % 6) == 0);
            if ((c % 6) == 0) chk("rl_pass", pass_cnt, c / 6);
        end
        tick();
        chk("rl_mid_phase", count, 10);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ps_paused", paused, 1);
            chk("ps_busy", busy, 1);
            chk("ps_count", count, 10);
        end
        pause = 1'b0;
        tick();
        chk("ps_resume", paused, 0);
        chk("ps_resume_count", count, 10);
        tick();
        chk("ps_step", count, 11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rl_abort_busy", busy, 0);
        chk("rl_abort_done", done, 0);
        chk("rl_abort_pass", pass_cnt, 3);

        // Handshake ignore and abort at 5.
        send_cmd(8'd0, 8'd9, 1'b0, 8'd0, 1'b0);
        cmd_start = 8'd100;
        cmd_valid = 1'b1;
        #1;
        chk("hs_ready_busy", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        chk("hs_ignored", count, 1);
        repeat (4) tick();
        chk("ab_at5", count, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_count", count, 5);
        chk("ab_done", done, 0);
        chk("ab_pass", pass_cnt, 0);
        chk("ab_ready", cmd_ready, 1);
        tick();
        chk("ab_stays", count, 5);

        // Abort together with pause.
        send_cmd(8'd0, 8'd9, 1'b0, 8'd0, 1'b0);
        abort = 1'b1; pause = 1'b1;
        tick();
        abort = 1'b0; pause = 1'b0;
        chk("abp_busy", busy, 0);
        chk("abp_paused", paused, 0);
        chk("abp_count", count, 0);

        // Abort during HOLD.
        send_cmd(8'd0, 8'd9, 1'b0, 8'd0, 1'b0);
        pause = 1'b1;
        tick();
        chk("abh_paused", paused, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0; pause = 1'b0;
        chk("abh_busy", busy, 0);
        chk("abh_paused_clr", paused, 0);

        // Saturation: start=end=0, reload, every RUN cycle is terminal.
        send_cmd(8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        chk("sat_pass0", pass_cnt, 0);
        done_hits = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (done === 1'b1) done_hits++;
            if (c == 1 || c == 254 || c == 255 || c == 256 || c == 300) begin
                exp_pass = (c > 255) ? 255 : c;
                chk("sat_pass", pass_cnt, exp_pass);
            end
        end
        chk("sat_done_hits", done_hits, 300);
        chk("sat_count", count, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("sat_abort_pass", pass_cnt, 255);
        send_cmd(8'd5, 8'd6, 1'b0, 8'd0, 1'b0);
        chk("new_cmd_pass", pass_cnt, 0);
        chk("new_cmd_count", count, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
